// File: rtl/fx_reg_slave_pkg.sv
// fx bus register-slave shared definitions: bus widths, register offsets, window decode helper.
// Latency: n/a (constants and a pure function only).
// Backpressure: n/a; the fx bus has no flow control, every strobe is serviced in its cycle.
// Contents:
//   FX_AW / FX_DW      fx bus address / data widths
//   OFS_*              register offsets inside the 16-byte window
//   fx_in_window()     true when an address falls inside the window of a given base
package fx_reg_slave_pkg;

  localparam int FX_AW = 22;
  localparam int FX_DW = 8;

  // Register map inside the 16-byte window (offset = addr[3:0]).
  localparam logic [3:0] OFS_ID      = 4'h0;  // RO identification byte
  localparam logic [3:0] OFS_SCRATCH = 4'h1;  // RW scratch byte
  localparam logic [3:0] OFS_CFG_LO  = 4'h2;  // RW shadow low byte of config
  localparam logic [3:0] OFS_CFG_HI  = 4'h3;  // RW config high byte, write commits
  localparam logic [3:0] OFS_SNAP0   = 4'h4;  // RO snapshot byte 0, read relatches
  localparam logic [3:0] OFS_SNAP1   = 4'h5;  // RO snapshot byte 1
  localparam logic [3:0] OFS_SNAP2   = 4'h6;  // RO snapshot byte 2
  localparam logic [3:0] OFS_SNAP3   = 4'h7;  // RO snapshot byte 3
  localparam logic [3:0] OFS_CTL     = 4'h8;  // WO write-1-pulse control, reads 0
  localparam logic [3:0] OFS_IRQ     = 4'h9;  // R/W1C sticky event flags

  // The window is 16 bytes, so the low nibble of both operands is ignored.
  function automatic logic fx_in_window(input logic [FX_AW-1:0] addr,
                                        input logic [FX_AW-1:0] base);
    return addr[FX_AW-1:4] == base[FX_AW-1:4];
  endfunction

endpackage

// File: rtl/fx_reg_slave_w1c_bank.sv
// 8-bit sticky event cell: per-bit set strobes, write-1-to-clear, with a registered OR.
// Latency: flags and o_any update on the edge that samples i_set / i_clr.
// Backpressure: none; set and clear are accepted every cycle, set wins over clear.
// Ports:
//   clk_sys  in   system clock, rising edge
//   rst      in   synchronous reset, active high (flags and o_any to 0)
//   i_set    in   per-bit set strobes
//   i_clr    in   per-bit clear mask (already qualified by the write decode)
//   o_flag   out  sticky flags
//   o_any    out  OR of the flags, registered on the same edge as the flags
module fx_w1c_bank #(
  parameter int W = 8
) (
  input  logic         clk_sys,
  input  logic         rst,
  input  logic [W-1:0] i_set,
  input  logic [W-1:0] i_clr,
  output logic [W-1:0] o_flag,
  output logic         o_any
);

  logic [W-1:0] r_flag;
  logic         r_any;
  logic [W-1:0] w_flag_nxt;

  // Clear is applied first and set ORed in afterwards so a new event is never lost.
  assign w_flag_nxt = (r_flag & ~i_clr) | i_set;

  always_ff @(posedge clk_sys) begin
    if (rst) begin
      r_flag <= '0;
      r_any  <= 1'b0;
    end else begin
      r_flag <= w_flag_nxt;
      r_any  <= |w_flag_nxt;
    end
  end

  assign o_flag = r_flag;
  assign o_any  = r_any;

endmodule

// File: rtl/fx_reg_slave.sv
// fx bus register slave: ID, scratch, committed config word, coherent status snapshot, ctl pulses, W1C irq.
// Latency: writes act on the sampling edge; fx_q is valid one cycle after fx_rd and held until the next fx_rd.
// Backpressure: none; every fx_wr / fx_rd strobe is serviced in its cycle, including both together.
// Ports:
//   clk_sys, rst               clock and synchronous active-high reset
//   fx_waddr, fx_wr, fx_data   byte write port
//   fx_raddr, fx_rd, fx_q      byte read port, fx_q registered
//   cfg_q, cfg_upd             committed config word and its one-cycle update pulse
//   stat_in                    live 32-bit status, captured on reads of offset 0x4
//   ctl_pulse                  one-cycle pulses for bits written as 1 at offset 0x8
//   evt_in, irq_flag, irq      event strobes, sticky flags, registered OR of flags
module fx_reg_slave
  import fx_reg_slave_pkg::*;
#(
  parameter logic [FX_AW-1:0] BASE_ADDR = 22'h000100,
  parameter logic [FX_DW-1:0] ID_VAL    = 8'hA5,
  parameter logic [15:0]      CFG_RST   = 16'h0000
) (
  input  logic             clk_sys,
  input  logic             rst,
  input  logic [FX_AW-1:0] fx_waddr,
  input  logic             fx_wr,
  input  logic [FX_DW-1:0] fx_data,
  input  logic [FX_AW-1:0] fx_raddr,
  input  logic             fx_rd,
  output logic [FX_DW-1:0] fx_q,
  output logic [15:0]      cfg_q,
  output logic             cfg_upd,
  input  logic [31:0]      stat_in,
  output logic [7:0]       ctl_pulse,
  input  logic [7:0]       evt_in,
  output logic [7:0]       irq_flag,
  output logic             irq
);

  // ---------------------------------------------------------------- decode
  logic       w_wr_hit;
  logic       w_rd_hit;
  logic [3:0] w_wofs;
  logic [3:0] w_rofs;

  assign w_wr_hit = fx_wr & fx_in_window(fx_waddr, BASE_ADDR);
  assign w_rd_hit = fx_rd & fx_in_window(fx_raddr, BASE_ADDR);
  assign w_wofs   = fx_waddr[3:0];
  assign w_rofs   = fx_raddr[3:0];

  // ---------------------------------------------------------------- state
  logic [FX_DW-1:0] r_fx_q;
  logic [FX_DW-1:0] r_scratch;
  logic [15:0]      r_shadow;
  logic [15:0]      r_cfg_q;
  logic             r_cfg_upd;
  logic [31:0]      r_snap;
  logic [7:0]       r_ctl_pulse;

  logic [7:0]       w_irq_clr;
  logic [7:0]       w_irq_flag;
  logic             w_irq;
  logic [FX_DW-1:0] w_rd_dat;

  // ---------------------------------------------------------------- read mux
  // Built from the current register values only, so a write in the same
  // cycle is never visible to the read (read-before-write). Offset 0x4
  // returns the live status byte because the snapshot is being loaded on
  // this very edge.
  always_comb begin
    w_rd_dat = '0;
    if (w_rd_hit) begin
      case (w_rofs)
        OFS_ID:      w_rd_dat = ID_VAL;
        OFS_SCRATCH: w_rd_dat = r_scratch;
        OFS_CFG_LO:  w_rd_dat = r_shadow[7:0];
        OFS_CFG_HI:  w_rd_dat = r_cfg_q[15:8];
        OFS_SNAP0:   w_rd_dat = stat_in[7:0];
        OFS_SNAP1:   w_rd_dat = r_snap[15:8];
        OFS_SNAP2:   w_rd_dat = r_snap[23:16];
        OFS_SNAP3:   w_rd_dat = r_snap[31:24];
        OFS_IRQ:     w_rd_dat = w_irq_flag;
        default:     w_rd_dat = '0;  // ctl is write-only, 0xA-0xF reserved
      endcase
    end
  end

  // ---------------------------------------------------------------- registers
  always_ff @(posedge clk_sys) begin
    if (rst) begin
      r_fx_q      <= '0;
      r_scratch   <= '0;
      r_shadow    <= CFG_RST;
      r_cfg_q     <= CFG_RST;
      r_cfg_upd   <= 1'b0;
      r_snap      <= '0;
      r_ctl_pulse <= '0;
    end else begin
      r_cfg_upd   <= 1'b0;
      r_ctl_pulse <= '0;

      // Any read strobe reloads fx_q; misses and empty offsets load 0.
      if (fx_rd) begin
        r_fx_q <= w_rd_dat;
      end

      // Capturing the full word on byte 0 keeps a 0x4..0x7 read sequence
      // coherent even though stat_in keeps moving.
      if (w_rd_hit && (w_rofs == OFS_SNAP0)) begin
        r_snap <= stat_in;
      end

      if (w_wr_hit) begin
        case (w_wofs)
          OFS_SCRATCH: r_scratch <= fx_data;
          OFS_CFG_LO:  r_shadow[7:0] <= fx_data;
          OFS_CFG_HI: begin
            // High-byte write commits the whole word in one step.
            r_cfg_q         <= {fx_data, r_shadow[7:0]};
            r_shadow[15:8]  <= fx_data;
            r_cfg_upd       <= 1'b1;
          end
          OFS_CTL:     r_ctl_pulse <= fx_data;
          default:     ;  // RO, W1C (handled in the bank) and reserved
        endcase
      end
    end
  end

  // ---------------------------------------------------------------- irq bank
  assign w_irq_clr = (w_wr_hit && (w_wofs == OFS_IRQ)) ? fx_data : 8'h00;

  fx_w1c_bank #(
    .W (8)
  ) u_irq_bank (
    .clk_sys (clk_sys),
    .rst     (rst),
    .i_set   (evt_in),
    .i_clr   (w_irq_clr),
    .o_flag  (w_irq_flag),
    .o_any   (w_irq)
  );

  // ---------------------------------------------------------------- outputs
  assign fx_q      = r_fx_q;
  assign cfg_q     = r_cfg_q;
  assign cfg_upd   = r_cfg_upd;
  assign ctl_pulse = r_ctl_pulse;
  assign irq_flag  = w_irq_flag;
  assign irq       = w_irq;

endmodule

// File: tb/tb_fx_reg_slave.sv
// Directed bench for fx_reg_slave: read data is checked through an expected-value queue.
// Latency: expects fx_q one cycle after fx_rd, writes visible after their sampling edge.
// Backpressure: n/a.
module tb_fx_reg_slave;

  localparam logic [21:0] BASE = 22'h000100;

  logic        clk_sys = 1'b0;
  logic        rst;
  logic [21:0] fx_waddr;
  logic        fx_wr;
  logic [7:0]  fx_data;
  logic [21:0] fx_raddr;
  logic        fx_rd;
  logic [7:0]  fx_q;
  logic [15:0] cfg_q;
  logic        cfg_upd;
  logic [31:0] stat_in;
  logic [7:0]  ctl_pulse;
  logic [7:0]  evt_in;
  logic [7:0]  irq_flag;
  logic        irq;

  int n_pass = 0;
  int n_chk  = 0;
  logic [7:0] exp_q[$];

  always #5 clk_sys = ~clk_sys;

  fx_reg_slave #(
    .BASE_ADDR (22'h000100),
    .ID_VAL    (8'hA5),
    .CFG_RST   (16'h0000)
  ) dut (
    .clk_sys   (clk_sys),
    .rst       (rst),
    .fx_waddr  (fx_waddr),
    .fx_wr     (fx_wr),
    .fx_data   (fx_data),
    .fx_raddr  (fx_raddr),
    .fx_rd     (fx_rd),
    .fx_q      (fx_q),
    .cfg_q     (cfg_q),
    .cfg_upd   (cfg_upd),
    .stat_in   (stat_in),
    .ctl_pulse (ctl_pulse),
    .evt_in    (evt_in),
    .irq_flag  (irq_flag),
    .irq       (irq)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // Pops the oldest expected read byte and compares it with fx_q.
  task automatic chk_rd(input string tag);
    logic [7:0] e;
    if (exp_q.size() == 0) begin
      n_chk++;
      $error("FAIL %s: scoreboard empty, observed %h expected a queued value", tag, fx_q);
    end else begin
      e = exp_q.pop_front();
      chk(tag, {24'h0, fx_q}, {24'h0, e});
    end
  endtask

  task automatic rd(input string tag, input logic [21:0] addr, input logic [7:0] exp);
    @(negedge clk_sys);
    fx_raddr = addr;
    fx_rd    = 1'b1;
    exp_q.push_back(exp);
    @(negedge clk_sys);
    fx_rd = 1'b0;
    chk_rd(tag);
  endtask

  task automatic wr(input logic [21:0] addr, input logic [7:0] dat);
    @(negedge clk_sys);
    fx_waddr = addr;
    fx_data  = dat;
    fx_wr    = 1'b1;
    @(negedge clk_sys);
    fx_wr = 1'b0;
  endtask

  initial begin
    rst      = 1'b1;
    fx_waddr = '0;
    fx_wr    = 1'b0;
    fx_data  = '0;
    fx_raddr = '0;
    fx_rd    = 1'b0;
    stat_in  = '0;
    evt_in   = '0;
    repeat (3) @(negedge clk_sys);

    // Reset state
    chk("rst_fx_q",     {24'h0, fx_q},      32'h0);
    chk("rst_cfg_q",    {16'h0, cfg_q},     32'h0);
    chk("rst_cfg_upd",  {31'h0, cfg_upd},   32'h0);
    chk("rst_ctl",      {24'h0, ctl_pulse}, 32'h0);
    chk("rst_irq_flag", {24'h0, irq_flag},  32'h0);
    chk("rst_irq",      {31'h0, irq},       32'h0);
    rst = 1'b0;

    // 1: ID, miss, reserved and write-only offsets
    rd("rd_id",       BASE + 22'h0,  8'hA5);
    rd("rd_miss",     BASE + 22'h10, 8'h00);
    rd("rd_id2",      BASE + 22'h0,  8'hA5);
    rd("rd_rsvd",     BASE + 22'hA,  8'h00);
    rd("rd_ctl_wo",   BASE + 22'h8,  8'h00);
    rd("rd_scratch0", BASE + 22'h1,  8'h00);
    // fx_q holds its value while fx_rd is low
    @(negedge clk_sys);
    chk("fx_q_hold", {24'h0, fx_q}, 32'h0);

    // 2: config commit
    wr(BASE + 22'h2, 8'h34);
    chk("cfg_lo_nocommit", {16'h0, cfg_q},   32'h0);
    chk("cfg_lo_noupd",    {31'h0, cfg_upd}, 32'h0);
    wr(BASE + 22'h3, 8'h12);
    chk("cfg_commit",     {16'h0, cfg_q},   32'h1234);
    chk("cfg_upd_pulse",  {31'h0, cfg_upd}, 32'h1);
    @(negedge clk_sys);
    chk("cfg_upd_once",   {31'h0, cfg_upd}, 32'h0);
    rd("rd_shadow_lo", BASE + 22'h2, 8'h34);
    rd("rd_cfg_hi",    BASE + 22'h3, 8'h12);
    // write to a missing window must not touch the config
    wr(BASE + 22'h13, 8'hEE);
    chk("cfg_miss_wr", {16'h0, cfg_q}, 32'h1234);

    // 3: coherent snapshot
    stat_in = 32'h11223344;
    rd("snap0", BASE + 22'h4, 8'h44);
    stat_in = 32'h0;
    rd("snap1", BASE + 22'h5, 8'h33);
    rd("snap2", BASE + 22'h6, 8'h22);
    rd("snap3", BASE + 22'h7, 8'h11);
    stat_in = 32'hCAFE_0077;
    rd("snap0_live", BASE + 22'h4, 8'h77);
    rd("snap3_new",  BASE + 22'h7, 8'hCA);

    // 4: back-to-back control pulses
    @(negedge clk_sys);
    fx_waddr = BASE + 22'h8;
    fx_data  = 8'h81;
    fx_wr    = 1'b1;
    @(negedge clk_sys);
    chk("ctl_pulse1", {24'h0, ctl_pulse}, 32'h81);
    @(negedge clk_sys);
    fx_wr = 1'b0;
    chk("ctl_pulse2", {24'h0, ctl_pulse}, 32'h81);
    @(negedge clk_sys);
    chk("ctl_pulse_end", {24'h0, ctl_pulse}, 32'h0);

    // 5: sticky flags with W1C, set wins over clear
    @(negedge clk_sys);
    evt_in = 8'h01;
    @(negedge clk_sys);
    evt_in = 8'h00;
    chk("irq_set_flag", {24'h0, irq_flag}, 32'h01);
    chk("irq_set",      {31'h0, irq},      32'h1);
    rd("rd_irq_flag", BASE + 22'h9, 8'h01);
    @(negedge clk_sys);
    fx_waddr = BASE + 22'h9;
    fx_data  = 8'h01;
    fx_wr    = 1'b1;
    evt_in   = 8'h01;
    @(negedge clk_sys);
    fx_wr  = 1'b0;
    evt_in = 8'h00;
    chk("irq_set_wins", {24'h0, irq_flag}, 32'h01);
    chk("irq_still",    {31'h0, irq},      32'h1);
    wr(BASE + 22'h9, 8'h01);
    chk("irq_cleared_flag", {24'h0, irq_flag}, 32'h00);
    chk("irq_cleared",      {31'h0, irq},      32'h0);
    // partial clear of a multi-bit pattern
    @(negedge clk_sys);
    evt_in = 8'h0C;
    @(negedge clk_sys);
    evt_in = 8'h00;
    wr(BASE + 22'h9, 8'h04);
    chk("irq_partial_flag", {24'h0, irq_flag}, 32'h08);
    chk("irq_partial",      {31'h0, irq},      32'h1);

    // 6: read-before-write on the same offset
    @(negedge clk_sys);
    fx_waddr = BASE + 22'h1;
    fx_data  = 8'h5A;
    fx_wr    = 1'b1;
    fx_raddr = BASE + 22'h1;
    fx_rd    = 1'b1;
    exp_q.push_back(8'h00);
    @(negedge clk_sys);
    fx_wr = 1'b0;
    fx_rd = 1'b0;
    chk_rd("rbw_old");
    rd("rbw_new", BASE + 22'h1, 8'h5A);

    // reset discards a pending shadow low byte
    wr(BASE + 22'h2, 8'h77);
    @(negedge clk_sys);
    rst = 1'b1;
    @(negedge clk_sys);
    rst = 1'b0;
    chk("rst_mid_cfg",  {16'h0, cfg_q},    32'h0);
    chk("rst_mid_flag", {24'h0, irq_flag}, 32'h0);
    wr(BASE + 22'h3, 8'hFF);
    chk("cfg_after_rst", {16'h0, cfg_q},   32'hFF00);
    chk("upd_after_rst", {31'h0, cfg_upd}, 32'h1);
    rd("scratch_after_rst", BASE + 22'h1, 8'h00);

    chk("scoreboard_drained", exp_q.size(), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
